// File: rtl/mem_req_responder_if.sv
// Control-unit request bus and DDR2 controller local port of the memory request responder.
// The slave modport is the responder's view; master is the surrounding environment's view.
interface mem_req_responder_if #(
    parameter int ADDR_W = 26,
    parameter int DATA_W = 32
);
    logic              memory_read_req;
    logic              memory_write_req;
    logic [ADDR_W-1:0] memory_addr;
    logic [DATA_W-1:0] memory_data_write;
    logic [DATA_W-1:0] memory_data_read;
    logic              memory_busy;
    logic              mem_err;

    logic              avl_ready;
    logic              avl_read_req;
    logic              avl_write_req;
    logic [ADDR_W-1:0] avl_addr;
    logic [DATA_W-1:0] avl_wdata;
    logic [DATA_W-1:0] avl_rdata;
    logic              avl_rdata_valid;

    modport slave (
        input  memory_read_req, memory_write_req, memory_addr, memory_data_write,
        output memory_data_read, memory_busy, mem_err,
        input  avl_ready, avl_rdata, avl_rdata_valid,
        output avl_read_req, avl_write_req, avl_addr, avl_wdata
    );

    modport master (
        output memory_read_req, memory_write_req, memory_addr, memory_data_write,
        input  memory_data_read, memory_busy, mem_err,
        output avl_ready, avl_rdata, avl_rdata_valid,
        input  avl_read_req, avl_write_req, avl_addr, avl_wdata
    );
endinterface

// File: rtl/mem_req_responder.sv
// Single-outstanding-request bridge from the control unit to the DDR2 controller local port,
// with a per-phase timeout and a sticky error flag for timeouts and read+write collisions.
module mem_req_responder #(
    parameter int ADDR_W  = 26,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input logic                clk,
    input logic                reset,
    mem_req_responder_if.slave bus
);
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST     = CNT_W'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(32'hDEADBEEF);

    typedef enum logic [2:0] {
        IDLE,
        WR_CMD,
        RD_CMD,
        RD_WAIT,
        DONE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              busy;
    logic              err;
    logic              collide;
    logic              rd_req;
    logic              wr_req;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rd_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            err     <= 1'b0;
            collide <= 1'b0;
            rd_req  <= 1'b0;
            wr_req  <= 1'b0;
            addr    <= '0;
            wdata   <= '0;
            rd_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A simultaneous read+write runs as the write and is flagged at completion.
                    if (bus.memory_write_req || bus.memory_read_req) begin
                        state   <= bus.memory_write_req ? WR_CMD : RD_CMD;
                        wr_req  <= bus.memory_write_req;
                        rd_req  <= !bus.memory_write_req;
                        collide <= bus.memory_write_req && bus.memory_read_req;
                        busy    <= 1'b1;
                        err     <= 1'b0;
                        cnt     <= '0;
                        addr    <= bus.memory_addr;
                        wdata   <= bus.memory_data_write;
                    end
                end
                WR_CMD: begin
                    if (bus.avl_ready) begin
                        state  <= DONE;
                        wr_req <= 1'b0;
                        busy   <= 1'b0;
                        err    <= collide;
                    end else if (cnt == CNT_LAST) begin
                        state  <= DONE;
                        wr_req <= 1'b0;
                        busy   <= 1'b0;
                        err    <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RD_CMD: begin
                    if (bus.avl_ready) begin
                        state  <= RD_WAIT;
                        rd_req <= 1'b0;
                        cnt    <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state   <= DONE;
                        rd_req  <= 1'b0;
                        busy    <= 1'b0;
                        err     <= 1'b1;
                        rd_data <= TIMEOUT_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RD_WAIT: begin
                    if (bus.avl_rdata_valid) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        rd_data <= bus.avl_rdata;
                    end else if (cnt == CNT_LAST) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        err     <= 1'b1;
                        rd_data <= TIMEOUT_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    rd_req <= 1'b0;
                    wr_req <= 1'b0;
                end
            endcase
        end
    end

    assign bus.memory_data_read = rd_data;
    assign bus.memory_busy      = busy;
    assign bus.mem_err          = err;
    assign bus.avl_read_req     = rd_req;
    assign bus.avl_write_req    = wr_req;
    assign bus.avl_addr         = addr;
    assign bus.avl_wdata        = wdata;
endmodule

// File: tb/tb_mem_req_responder.sv
// Directed and random checks of mem_req_responder against a controller model and reference memory.
module tb_mem_req_responder;
    localparam int AW = 26;
    localparam int DW = 32;
    localparam int TO = 20;

    logic clk;
    logic reset;
    int   compared   = 0;
    int   mismatched = 0;

    int   ready_delay  = 0;
    int   rdata_lat    = 0;
    bit   rdata_enable = 1;

    logic [59:0]   cmd_q[$];
    logic [DW-1:0] rd_q[$];
    logic [DW-1:0] ref_mem[logic [AW-1:0]];
    logic [DW-1:0] slave_mem[logic [AW-1:0]];

    mem_req_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_req_responder #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    function automatic logic [DW-1:0] slave_rd(input logic [AW-1:0] a);
        return slave_mem.exists(a) ? slave_mem[a] : '0;
    endfunction

    // Controller model: ready after ready_delay stalled cycles, read data rdata_lat cycles into RD_WAIT
    initial begin
        int            wait_cnt;
        int            rd_cnt;
        bit            rd_pending;
        logic [AW-1:0] rd_addr;
        logic [59:0]   exp_cmd;
        wait_cnt   = 0;
        rd_cnt     = 0;
        rd_pending = 0;
        rd_addr    = '0;
        bus.avl_ready       = 1'b0;
        bus.avl_rdata       = '0;
        bus.avl_rdata_valid = 1'b0;
        forever begin
            @(negedge clk);
            bus.avl_rdata_valid = 1'b0;
            if (rd_pending) begin
                if (rd_cnt == 0) begin
                    bus.avl_rdata_valid = 1'b1;
                    bus.avl_rdata       = slave_rd(rd_addr);
                    rd_pending          = 0;
                end else begin
                    rd_cnt--;
                end
            end
            bus.avl_ready = 1'b0;
            if (bus.avl_read_req || bus.avl_write_req) begin
                if (wait_cnt >= ready_delay) begin
                    bus.avl_ready = 1'b1;
                    wait_cnt      = 0;
                    if (cmd_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $error("FAIL cmd_unexpected: observed wr=%0b rd=%0b addr=%0h required none",
                               bus.avl_write_req, bus.avl_read_req, bus.avl_addr);
                    end else begin
                        exp_cmd = cmd_q.pop_front();
                        check("cmd", {bus.avl_write_req, bus.avl_read_req, bus.avl_addr,
                                      bus.avl_write_req ? bus.avl_wdata : 32'd0}, exp_cmd);
                    end
                    if (bus.avl_write_req) slave_mem[bus.avl_addr] = bus.avl_wdata;
                    if (bus.avl_read_req && rdata_enable) begin
                        rd_pending = 1;
                        rd_cnt     = rdata_lat;
                        rd_addr    = bus.avl_addr;
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic do_op(input logic rd, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int exp_lat, input logic exp_err,
                         input bit pulse_extra);
        int lat;
        int strobes;
        bit stable;
        @(negedge clk);
        bus.memory_read_req   = rd;
        bus.memory_write_req  = wr;
        bus.memory_addr       = a;
        bus.memory_data_write = d;
        if (wr) begin
            cmd_q.push_back({1'b1, 1'b0, a, d});
            ref_mem[a] = d;
        end else begin
            cmd_q.push_back({1'b0, 1'b1, a, 32'd0});
            rd_q.push_back(rdata_enable ? ref_rd(a) : 32'hDEADBEEF);
        end
        @(negedge clk);
        lat = 1;
        bus.memory_read_req  = 1'b0;
        bus.memory_write_req = 1'b0;
        check("err_clear_on_accept", bus.mem_err, 1'b0);
        strobes = 0;
        stable  = 1;
        while (bus.memory_busy && lat < 200) begin
            if (bus.avl_read_req || bus.avl_write_req) begin
                strobes++;
                if (bus.avl_addr !== a || (wr && bus.avl_wdata !== d)) stable = 0;
            end
            if (pulse_extra) begin
                bus.memory_read_req  = lat[0];
                bus.memory_write_req = !lat[0];
            end
            @(negedge clk);
            lat++;
        end
        bus.memory_read_req  = 1'b0;
        bus.memory_write_req = 1'b0;
        check("latency", lat, exp_lat);
        check("strobe_cycles", strobes, ready_delay + 1);
        check("strobe_stable", stable, 1'b1);
        check("mem_err", bus.mem_err, exp_err);
        check("strobes_low_done", {bus.avl_read_req, bus.avl_write_req}, 2'b00);
        if (!wr) check("read_data", bus.memory_data_read, rd_q.pop_front());
    endtask

    initial begin
        bus.memory_read_req   = 1'b0;
        bus.memory_write_req  = 1'b0;
        bus.memory_addr       = '0;
        bus.memory_data_write = '0;
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_ctrl", {bus.memory_busy, bus.mem_err, bus.avl_read_req, bus.avl_write_req}, 4'b0);
        check("reset_data", {bus.memory_data_read, bus.avl_addr, bus.avl_wdata}, 90'd0);
        reset = 1'b1;

        // Minimum-latency write
        ready_delay = 0;
        do_op(1'b0, 1'b1, 26'h0000123, 32'hCAFEF00D, 2, 1'b0, 0);

        // Read with a stalled command phase and slow return
        ready_delay = 5;
        rdata_lat   = 4;
        do_op(1'b1, 1'b0, 26'h0000123, 32'h0, 12, 1'b0, 0);

        // Minimum-latency read
        ready_delay = 0;
        rdata_lat   = 0;
        do_op(1'b1, 1'b0, 26'h0000123, 32'h0, 3, 1'b0, 0);

        // Read data never returns
        rdata_enable = 0;
        do_op(1'b1, 1'b0, 26'h0000055, 32'h0, TO + 2, 1'b1, 0);
        rdata_enable = 1;
        do_op(1'b0, 1'b1, 26'h0000077, 32'h00000001, 2, 1'b0, 0);

        // Collision, with extra request pulses while busy
        ready_delay = 3;
        do_op(1'b1, 1'b1, 26'h0000200, 32'h00001234, 5, 1'b1, 1);
        repeat (4) @(negedge clk);
        check("no_extra_cmd", cmd_q.size(), 0);
        check("idle_after_collision", {bus.memory_busy, bus.avl_read_req, bus.avl_write_req}, 3'b0);

        // Reset during RD_WAIT, then a late read return
        ready_delay = 0;
        rdata_lat   = 6;
        do_op(1'b0, 1'b1, 26'h0000300, 32'h0BADF00D, 2, 1'b0, 0);
        @(negedge clk);
        bus.memory_read_req = 1'b1;
        bus.memory_addr     = 26'h0000123;
        cmd_q.push_back({1'b0, 1'b1, 26'h0000123, 32'd0});
        @(negedge clk);
        bus.memory_read_req = 1'b0;
        @(negedge clk);
        check("rd_wait_busy", {bus.memory_busy, bus.avl_read_req}, 2'b10);
        reset = 1'b0;
        #1;
        check("async_reset_ctrl", {bus.memory_busy, bus.mem_err, bus.avl_read_req, bus.avl_write_req}, 4'b0);
        check("async_reset_data", {bus.memory_data_read, bus.avl_addr, bus.avl_wdata}, 90'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        check("late_rdata_ignored", {bus.memory_busy, bus.mem_err, bus.memory_data_read}, 34'd0);
        rdata_lat = 0;
        do_op(1'b1, 1'b0, 26'h0000300, 32'h0, 3, 1'b0, 0);

        // Random back-to-back traffic against the reference memory
        for (int i = 0; i < 1000; i++) begin
            logic          wr;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            int            exp_lat;
            ready_delay = $urandom_range(0, 3);
            rdata_lat   = $urandom_range(0, 3);
            wr          = 1'($urandom_range(0, 1));
            a           = 26'h0000100 + AW'($urandom_range(0, 15));
            d           = $urandom;
            exp_lat     = wr ? 2 + ready_delay : 3 + ready_delay + rdata_lat;
            do_op(!wr, wr, a, d, exp_lat, 1'b0, 0);
        end

        repeat (5) @(negedge clk);
        check("cmd_q_drained", cmd_q.size(), 0);
        check("rd_q_drained", rd_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
